clk_div_prog: RTL



---
 rtl/clk_div_prog.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider: per-channel level plus rising-edge tick.
// Optional per-channel enable input when CLK_DIV_CH_EN is defined.

module clk_div_lane #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_DIV = '0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             wrap,
    output logic             idle,
    output logic             clk_out,
    output logic             tick
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;

    assign wrap = (cnt == div - CNT_W'(1));
    assign idle = (div == '0) || !en;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            div     <= RST_DIV;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            // Outputs come from the pre-update count so the old period always completes.
            if (idle) begin
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else begin
                clk_out <= (cnt < (div >> 1));
                tick    <= (cnt == '0);
            end
            if (load) begin
                div <= load_div;
                cnt <= '0;
            end else if (idle || restart || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module clk_div_prog #(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    input  logic              sync_restart,
`ifdef CLK_DIV_CH_EN
    input  logic [NUM_CH-1:0] ch_en,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);
    logic             pending;
    logic [CH_W-1:0]  pend_ch;
    logic [CNT_W-1:0] pend_div;
    logic             xfer, bad, direct;
    logic [CNT_W-1:0] load_div;
    logic [NUM_CH-1:0] en, load, wrap, idle;

`ifdef CLK_DIV_CH_EN
    assign en = ch_en;
`else
    assign en = '1;
`endif

    assign cfg_ready = !pending;
    assign xfer      = cfg_valid && cfg_ready;
    assign bad       = (32'(cfg_ch) >= NUM_CH);
    // A transfer coinciding with a restart bypasses the pending slot.
    assign direct    = xfer && !bad && sync_restart;
    assign load_div  = pending ? pend_div : cfg_div;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = (pending && (pend_ch == CH_W'(i)) && (wrap[i] || idle[i] || sync_restart))
                       || (direct && (cfg_ch == CH_W'(i)));

        clk_div_lane #(
            .CNT_W   (CNT_W),
            .RST_DIV (CNT_W'(1) << (i + 1))
        ) u_lane (
            .clk_in   (clk_in),
            .rst      (rst),
            .en       (en[i]),
            .restart  (sync_restart),
            .load     (load[i]),
            .load_div (load_div),
            .wrap     (wrap[i]),
            .idle     (idle[i]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pending  <= 1'b0;
            pend_ch  <= '0;
            pend_div <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= xfer && bad;
            if (pending) begin
                pending <= !(|load);
            end else if (xfer && !bad && !sync_restart) begin
                pending  <= 1'b1;
                pend_ch  <= cfg_ch;
                pend_div <= cfg_div;
            end
        end
    end
endmodule
